// File: rtl/register_file_mp_if.sv
// ---------------------------------------------------------------------------
// register_file_mp_if
//
// Purpose:
//   Bundles the write-back, issue-read and clear/status signals of the
//   multi-port register file so the design and its users share one port
//   declaration.
//
// Signals (direction seen from the register file, i.e. the slave modport):
//   clear_req    in   single-cycle request to re-zero the whole array
//   init_done    out  array is usable (sweep finished)
//   wr_en        in   per-write-port enable
//   wr_addr      in   per-write-port address
//   wr_data      in   per-write-port data
//   rd_addr      in   per-read-port address
//   rd_data      out  per-read-port data, combinational
//   wr_conflict  out  registered pulse, two enabled ports hit one address
//   wr_dropped   out  registered pulse, a write arrived during a sweep
// ---------------------------------------------------------------------------
interface register_file_mp_if #(
    parameter int XLEN            = 32,
    parameter int NUM_REGS        = 32,
    parameter int NUM_READ_PORTS  = 2,
    parameter int NUM_WRITE_PORTS = 2
);
    localparam int AW = $clog2(NUM_REGS);

    logic                                       clear_req;
    logic                                       init_done;
    logic [NUM_WRITE_PORTS-1:0]                 wr_en;
    logic [NUM_WRITE_PORTS-1:0][AW-1:0]         wr_addr;
    logic [NUM_WRITE_PORTS-1:0][XLEN-1:0]       wr_data;
    logic [NUM_READ_PORTS-1:0][AW-1:0]          rd_addr;
    logic [NUM_READ_PORTS-1:0][XLEN-1:0]        rd_data;
    logic                                       wr_conflict;
    logic                                       wr_dropped;

    // The issue/writeback side drives requests and observes status
    modport master (
        output clear_req,
        output wr_en,
        output wr_addr,
        output wr_data,
        output rd_addr,
        input  init_done,
        input  rd_data,
        input  wr_conflict,
        input  wr_dropped
    );

    // The register file itself
    modport slave (
        input  clear_req,
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  rd_addr,
        output init_done,
        output rd_data,
        output wr_conflict,
        output wr_dropped
    );
endinterface

// File: rtl/register_file_mp.sv
// ---------------------------------------------------------------------------
// register_file_mp
//
// Purpose:
//   Parametrised multi-port integer register file sitting between issue
//   (combinational reads) and writeback (clocked writes). Entry 0 is
//   hardwired to zero. The storage array has no per-bit reset; instead a
//   sweep engine writes zero into one entry per cycle after reset or on a
//   clear request, and the file reports itself usable via init_done.
//
// Parameters:
//   XLEN             data width of every entry
//   NUM_REGS         number of entries (>= 2)
//   NUM_READ_PORTS   number of combinational read ports
//   NUM_WRITE_PORTS  number of write ports, higher index wins on collisions
//   BYPASS           1: reads see same-cycle write data, 0: stored data only
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, restarts the sweep at entry 0
//   bus    register_file_mp_if slave modport (writes, reads, clear, status)
// ---------------------------------------------------------------------------
module register_file_mp #(
    parameter int XLEN            = 32,
    parameter int NUM_REGS        = 32,
    parameter int NUM_READ_PORTS  = 2,
    parameter int NUM_WRITE_PORTS = 2,
    parameter bit BYPASS          = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    register_file_mp_if.slave  bus
);

    localparam int            AW       = $clog2(NUM_REGS);
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

    typedef enum logic {
        SWEEP,
        READY
    } state_e;

    state_e                                 state_q, state_d;
    logic [AW-1:0]                          sweep_ptr_q, sweep_ptr_d;
    logic                                   wr_conflict_q, wr_conflict_d;
    logic                                   wr_dropped_q, wr_dropped_d;
    logic [XLEN-1:0]                        mem_q [NUM_REGS];
    logic [NUM_WRITE_PORTS-1:0]             wr_valid;
    logic [NUM_READ_PORTS-1:0][XLEN-1:0]    rd_data_o;

    // An address names a real, writable entry only if it is nonzero and
    // inside the array; this matters when NUM_REGS is not a power of two.
    function automatic logic addr_ok(input logic [AW-1:0] addr);
        return (addr != '0) && ({1'b0, addr} < (AW + 1)'(NUM_REGS));
    endfunction

    // Qualify each write port: it only takes effect in READY and only for a
    // real, nonzero entry. Writes to entry 0 or out of range vanish here.
    always_comb begin
        wr_valid = '0;
        for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
            wr_valid[p] = (state_q == READY) && bus.wr_en[p] && addr_ok(bus.wr_addr[p]);
        end
    end

    // Event detection for the two status pulses. During a sweep any raised
    // enable counts as a dropped write; in READY two qualified ports aiming
    // at the same entry form a conflict (the higher port still wins below).
    always_comb begin
        wr_conflict_d = 1'b0;
        wr_dropped_d  = 1'b0;
        if (state_q == SWEEP) begin
            wr_dropped_d = |bus.wr_en;
        end else begin
            for (int i = 0; i < NUM_WRITE_PORTS; i++) begin
                for (int j = i + 1; j < NUM_WRITE_PORTS; j++) begin
                    if (wr_valid[i] && wr_valid[j] && (bus.wr_addr[i] == bus.wr_addr[j])) begin
                        wr_conflict_d = 1'b1;
                    end
                end
            end
        end
    end

    // Next-state logic for the sweep engine. SWEEP walks the pointer from 0
    // to the last entry and then hands over to READY; a clear request in
    // READY restarts the walk. Clear requests during a sweep are ignored so
    // an in-flight sweep is never stretched.
    always_comb begin
        state_d     = state_q;
        sweep_ptr_d = sweep_ptr_q;
        case (state_q)
            SWEEP: begin
                if (sweep_ptr_q == LAST_IDX) begin
                    state_d     = READY;
                    sweep_ptr_d = '0;
                end else begin
                    sweep_ptr_d = sweep_ptr_q + AW'(1);
                end
            end
            READY: begin
                if (bus.clear_req) begin
                    state_d     = SWEEP;
                    sweep_ptr_d = '0;
                end
            end
            default: begin
                state_d     = SWEEP;
                sweep_ptr_d = '0;
            end
        endcase
    end

    // Control registers. Reset always lands in SWEEP at entry 0 so the array
    // is fully rewritten before anyone is allowed to use it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= SWEEP;
            sweep_ptr_q   <= '0;
            wr_conflict_q <= 1'b0;
            wr_dropped_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            sweep_ptr_q   <= sweep_ptr_d;
            wr_conflict_q <= wr_conflict_d;
            wr_dropped_q  <= wr_dropped_d;
        end
    end

    // Storage array, deliberately without reset. In SWEEP the engine zeroes
    // the entry under the pointer; in READY the write ports commit in
    // ascending order so the last nonblocking assignment, i.e. the highest
    // enabled port, wins when several ports hit the same entry.
    always_ff @(posedge clk) begin
        if (state_q == SWEEP) begin
            mem_q[sweep_ptr_q] <= '0;
        end else begin
            for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
                if (wr_valid[p]) begin
                    mem_q[bus.wr_addr[p]] <= bus.wr_data[p];
                end
            end
        end
    end

    // Combinational read ports. Nothing is visible until the sweep is done,
    // entry 0 and out-of-range addresses read zero, and with BYPASS the
    // highest qualified write port aimed at the same entry overrides the
    // stored value so issue sees the value being written back this cycle.
    always_comb begin
        rd_data_o = '0;
        for (int r = 0; r < NUM_READ_PORTS; r++) begin
            if ((state_q == READY) && addr_ok(bus.rd_addr[r])) begin
                rd_data_o[r] = mem_q[bus.rd_addr[r]];
                if (BYPASS) begin
                    for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
                        if (wr_valid[p] && (bus.wr_addr[p] == bus.rd_addr[r])) begin
                            rd_data_o[r] = bus.wr_data[p];
                        end
                    end
                end
            end
        end
    end

    assign bus.rd_data     = rd_data_o;
    assign bus.init_done   = (state_q == READY);
    assign bus.wr_conflict = wr_conflict_q;
    assign bus.wr_dropped  = wr_dropped_q;

endmodule
